// File: rtl/tree_pkg.sv
// Shared decision-tree node constants: word geometry, field offsets and the
// node-fetch FSM state encoding.
package tree_pkg;

    localparam int FEATURES        = 3;
    localparam int COEFF_BIT_DEPTH = 4;
    localparam int BIAS_BIT_DEPTH  = 10;
    localparam int WORDS           = 8;

    localparam int ADDR_W  = $clog2(WORDS);
    localparam int COEFF_W = (FEATURES - 1) * COEFF_BIT_DEPTH;
    localparam int WORD_W  = 3 + FEATURES + COEFF_W + BIAS_BIT_DEPTH;

    // Field LSB positions, packed MSB-first as reserved, child, onehot, coeff, bias.
    localparam int BIAS_LSB   = 0;
    localparam int COEFF_LSB  = BIAS_LSB + BIAS_BIT_DEPTH;
    localparam int ONEHOT_LSB = COEFF_LSB + COEFF_W;
    localparam int CHILD_LSB  = ONEHOT_LSB + FEATURES;
    localparam int RSV_BIT    = CHILD_LSB + 2;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD_ISSUE,
        RD_CAPTURE,
        RSP
    } fetch_state_e;

endpackage

// File: rtl/tree_node_unpack.sv
// Combinational split of a tree-node word into its fields.
// Optional malformed-onehot check enabled by TREE_NODE_FETCH_ONEHOT_CHECK_EN.
module tree_node_unpack
    import tree_pkg::*;
(
    input  logic [WORD_W-1:0]         word,
    output logic [1:0]                child,
    output logic [FEATURES-1:0]       onehot,
    output logic [COEFF_W-1:0]        coeff,
    output logic [BIAS_BIT_DEPTH-1:0] bias,
    output logic                      onehot_err
);

    logic unused_rsv;

    assign child      = word[CHILD_LSB +: 2];
    assign onehot     = word[ONEHOT_LSB +: FEATURES];
    assign coeff      = word[COEFF_LSB +: COEFF_W];
    assign bias       = word[BIAS_LSB +: BIAS_BIT_DEPTH];
    assign unused_rsv = word[RSV_BIT];

`ifdef TREE_NODE_FETCH_ONEHOT_CHECK_EN
    // Zero bits set, or clearing the lowest set bit still leaves one set.
    assign onehot_err = (onehot == '0) ||
                        ((onehot & (onehot - FEATURES'(1))) != '0);
`else
    assign onehot_err = 1'b0;
`endif

endmodule

// File: rtl/tree_node_fetch.sv
// Bus initiator for the tree coefficient memory: valid/ready node requests in,
// single-port ce/we/a/d memory bus out, unpacked read responses back.
// Optional onehot check: define TREE_NODE_FETCH_ONEHOT_CHECK_EN.
module tree_node_fetch
    import tree_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_we,
    input  logic [ADDR_W-1:0]         req_addr,
    input  logic [WORD_W-1:0]         req_wdata,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [WORD_W-1:0]         rsp_word,
    output logic [1:0]                rsp_child,
    output logic [FEATURES-1:0]       rsp_onehot,
    output logic [COEFF_W-1:0]        rsp_coeff,
    output logic [BIAS_BIT_DEPTH-1:0] rsp_bias,
    output logic                      rsp_err,
    output logic                      mem_ce,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_a,
    inout  wire  [WORD_W-1:0]         mem_d
);

    fetch_state_e      state_q, state_d;
    logic              mem_ce_q, mem_ce_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_a_q, mem_a_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic [WORD_W-1:0] rsp_word_q, rsp_word_d;
    logic              node_err;

    always_comb begin
        state_d    = state_q;
        mem_a_d    = mem_a_q;
        wdata_d    = wdata_q;
        rsp_word_d = rsp_word_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    mem_a_d = req_addr;
                    wdata_d = req_wdata;
                    state_d = req_we ? WR : RD_ISSUE;
                end
            end
            WR:         state_d = IDLE;
            RD_ISSUE:   state_d = RD_CAPTURE;
            RD_CAPTURE: begin
                rsp_word_d = mem_d;
                state_d    = RSP;
            end
            RSP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default:    state_d = IDLE;
        endcase
        // Bus strobes are registered, so they follow the state being entered.
        mem_ce_d = (state_d == WR) || (state_d == RD_ISSUE);
        mem_we_d = (state_d == WR);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            mem_ce_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_a_q    <= '0;
            rsp_word_q <= '0;
        end else begin
            state_q    <= state_d;
            mem_ce_q   <= mem_ce_d;
            mem_we_q   <= mem_we_d;
            mem_a_q    <= mem_a_d;
            rsp_word_q <= rsp_word_d;
        end
    end

    always_ff @(posedge clk) begin
        wdata_q <= wdata_d;
    end

    tree_node_unpack u_unpack (
        .word       (rsp_word_q),
        .child      (rsp_child),
        .onehot     (rsp_onehot),
        .coeff      (rsp_coeff),
        .bias       (rsp_bias),
        .onehot_err (node_err)
    );

    assign req_ready = (state_q == IDLE) && reset;
    assign rsp_valid = (state_q == RSP);
    assign rsp_word  = rsp_word_q;
    assign rsp_err   = rsp_valid && node_err;
    assign mem_ce    = mem_ce_q;
    assign mem_we    = mem_we_q;
    assign mem_a     = mem_a_q;
    // The memory owns the bus except during our write cycle.
    assign mem_d     = (mem_ce_q && mem_we_q) ? wdata_q : 'z;

endmodule

// File: tb/tb_tree_node_fetch.sv
// Directed bench for tree_node_fetch with a behavioural single-port memory.
module tb_tree_node_fetch;
    import tree_pkg::*;

`ifdef TREE_NODE_FETCH_ONEHOT_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic                      clk = 1'b0;
    logic                      reset = 1'b0;
    logic                      req_valid = 1'b0;
    logic                      req_ready;
    logic                      req_we = 1'b0;
    logic [ADDR_W-1:0]         req_addr = '0;
    logic [WORD_W-1:0]         req_wdata = '0;
    logic                      rsp_valid;
    logic                      rsp_ready = 1'b0;
    logic [WORD_W-1:0]         rsp_word;
    logic [1:0]                rsp_child;
    logic [FEATURES-1:0]       rsp_onehot;
    logic [COEFF_W-1:0]        rsp_coeff;
    logic [BIAS_BIT_DEPTH-1:0] rsp_bias;
    logic                      rsp_err;
    logic                      mem_ce;
    logic                      mem_we;
    logic [ADDR_W-1:0]         mem_a;
    wire  [WORD_W-1:0]         mem_d;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    tree_node_fetch dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_word   (rsp_word),
        .rsp_child  (rsp_child),
        .rsp_onehot (rsp_onehot),
        .rsp_coeff  (rsp_coeff),
        .rsp_bias   (rsp_bias),
        .rsp_err    (rsp_err),
        .mem_ce     (mem_ce),
        .mem_we     (mem_we),
        .mem_a      (mem_a),
        .mem_d      (mem_d)
    );

    // Memory model: samples address on ce, drives read data the following cycle.
    logic              load = 1'b1;
    logic [WORD_W-1:0] mem_m [WORDS];
    logic [WORD_W-1:0] rd_q;
    logic              rd_en = 1'b0;

    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < WORDS; i++) mem_m[i] <= '0;
            mem_m[0] <= 24'h111111;
            mem_m[2] <= 24'h269555;
            mem_m[7] <= 24'h0ABCDE;
        end else if (mem_ce && mem_we) begin
            mem_m[mem_a] <= mem_d;
        end
        rd_en <= mem_ce && !mem_we && !load;
        if (mem_ce && !mem_we) rd_q <= mem_m[mem_a];
    end

    assign mem_d = rd_en ? rd_q : 'z;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic bad_onehot(input logic [WORD_W-1:0] w);
        logic [FEATURES-1:0] oh;
        oh = w[ONEHOT_LSB +: FEATURES];
        return CHK_EN && ($countones(oh) != 1);
    endfunction

    task automatic chk_fields(input string tag, input logic [WORD_W-1:0] w);
        chk({tag, "_word"},   32'(rsp_word),   32'(w));
        chk({tag, "_child"},  32'(rsp_child),  32'(w[22:21]));
        chk({tag, "_onehot"}, 32'(rsp_onehot), 32'(w[20:18]));
        chk({tag, "_coeff"},  32'(rsp_coeff),  32'(w[17:10]));
        chk({tag, "_bias"},   32'(rsp_bias),   32'(w[9:0]));
        chk({tag, "_err"},    32'(rsp_err),    32'(bad_onehot(w)));
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [WORD_W-1:0] d);
        req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
        tick();
        req_valid = 1'b0; req_we = 1'b0;
        chk("wr_ce", 32'(mem_ce), 1);
        chk("wr_we", 32'(mem_we), 1);
        chk("wr_a", 32'(mem_a), 32'(a));
        chk("wr_bus", 32'(mem_d), 32'(d));
        chk("wr_busy", 32'(req_ready), 0);
        tick();
        chk("wr_ce_off", 32'(mem_ce), 0);
        chk("wr_ready", 32'(req_ready), 1);
        chk("wr_mem", 32'(mem_m[a]), 32'(d));
    endtask

    // Accept a read, check the three busy cycles and consume the response.
    task automatic do_read(input logic [ADDR_W-1:0] a, input logic [WORD_W-1:0] w, input logic keep_rdy);
        req_valid = 1'b1; req_we = 1'b0; req_addr = a;
        tick();
        req_valid = 1'b0;
        chk("rd_iss_ce", 32'(mem_ce), 1);
        chk("rd_iss_we", 32'(mem_we), 0);
        chk("rd_iss_a", 32'(mem_a), 32'(a));
        chk("rd_busy0", 32'(req_ready), 0);
        tick();
        chk("rd_cap_ce", 32'(mem_ce), 0);
        chk("rd_busy1", 32'(req_ready), 0);
        chk("rd_cap_vld", 32'(rsp_valid), 0);
        tick();
        chk("rd_vld", 32'(rsp_valid), 1);
        chk("rd_busy2", 32'(req_ready), 0);
        chk_fields("rd", w);
        rsp_ready = 1'b1;
        tick();
        chk("rd_done", 32'(rsp_valid), 0);
        chk("rd_ready", 32'(req_ready), 1);
        rsp_ready = keep_rdy;
    endtask

    initial begin
        logic [WORD_W-1:0] held;

        #3;
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_vld", 32'(rsp_valid), 0);
        chk("rst_err", 32'(rsp_err), 0);
        chk("rst_ce", 32'(mem_ce), 0);
        chk("rst_we", 32'(mem_we), 0);
        chk("rst_a", 32'(mem_a), 0);
        chk("rst_word", 32'(rsp_word), 0);
        chk("rst_onehot", 32'(rsp_onehot), 0);
        tick();
        tick();
        reset = 1'b1;
        load  = 1'b0;
        #1;
        chk("rel_ready", 32'(req_ready), 1);

        // Write then read back; fields of 24'h5A1234 worked out by hand.
        do_write(3'd3, 24'h5A1234);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 3'd3;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        chk("rb_vld", 32'(rsp_valid), 1);
        chk("rb_word", 32'(rsp_word), 32'h5A1234);
        chk("rb_child", 32'(rsp_child), 32'h2);
        chk("rb_onehot", 32'(rsp_onehot), 32'h6);
        chk("rb_coeff", 32'(rsp_coeff), 32'h84);
        chk("rb_bias", 32'(rsp_bias), 32'h234);
        chk("rb_err", 32'(rsp_err), 32'(CHK_EN));
        rsp_ready = 1'b1;
        tick();
        chk("rb_done", 32'(rsp_valid), 0);

        // Back-to-back reads with rsp_ready left high throughout.
        do_read(3'd0, 24'h111111, 1'b1);
        do_read(3'd7, 24'h0ABCDE, 1'b0);

        // Stalled response with a write held pending behind it.
        req_valid = 1'b1; req_we = 1'b0; req_addr = 3'd2;
        tick();
        req_we = 1'b1; req_wdata = 24'hFFFFFF;
        tick();
        tick();
        chk("st_vld0", 32'(rsp_valid), 1);
        held = rsp_word;
        chk_fields("st0", 24'h269555);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("st_vld", 32'(rsp_valid), 1);
            chk("st_word", 32'(rsp_word), 32'(held));
            chk("st_coeff", 32'(rsp_coeff), 32'hA5);
            chk("st_ready", 32'(req_ready), 0);
            chk("st_no_ce", 32'(mem_ce), 0);
            chk("st_no_we", 32'(mem_we), 0);
        end
        chk("st_mem_kept", 32'(mem_m[2]), 32'h269555);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("st_done", 32'(rsp_valid), 0);
        chk("st_ready_back", 32'(req_ready), 1);
        tick();
        req_valid = 1'b0; req_we = 1'b0;
        chk("pw_we", 32'(mem_we), 1);
        chk("pw_a", 32'(mem_a), 2);
        chk("pw_bus", 32'(mem_d), 32'hFFFFFF);
        tick();
        chk("pw_mem", 32'(mem_m[2]), 32'hFFFFFF);

        // Malformed onehot fields: two bits set, then none set.
        do_write(3'd4, 24'h0C0001);
        do_write(3'd5, 24'h000002);
        do_read(3'd4, 24'h0C0001, 1'b0);
        do_read(3'd5, 24'h000002, 1'b0);

        // Reset during RD_CAPTURE discards the read.
        req_valid = 1'b1; req_we = 1'b0; req_addr = 3'd7;
        tick();
        req_valid = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        chk("ar_ce", 32'(mem_ce), 0);
        chk("ar_we", 32'(mem_we), 0);
        chk("ar_vld", 32'(rsp_valid), 0);
        chk("ar_ready", 32'(req_ready), 0);
        tick();
        reset = 1'b1;
        #1;
        chk("ar_rel_ready", 32'(req_ready), 1);
        tick();
        chk("ar_no_rsp", 32'(rsp_valid), 0);
        do_read(3'd2, 24'hFFFFFF, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/tree_node_fetch.md
# tree_node_fetch

Bus initiator for the decision-tree coefficient memory. Accepts node read and write requests over a valid/ready interface and drives the memory's single-port ce/we/a/d bus, including the shared tri-state data line. Unpacks each read word into tree-node fields and presents them to the tree-walk logic through a stallable response interface.

## Interface
- FEATURES, 3: feature count per node.
- COEFF_BIT_DEPTH, 4: width of each non-unit coefficient.
- BIAS_BIT_DEPTH, 10: bias width.
- WORDS, 8: memory depth in nodes.
- WORD_W, 3+FEATURES+(FEATURES-1)*COEFF_BIT_DEPTH+BIAS_BIT_DEPTH (24): memory word width.
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when high with req_valid.
- req_we  in  1  1=write, 0=read.
- req_addr  in  $clog2(WORDS)  node index.
- req_wdata  in  WORD_W  word to write; ignored on reads.
- rsp_valid  out  1  read response present.
- rsp_ready  in  1  consumer takes response.
- rsp_word  out  WORD_W  raw read word.
- rsp_child  out  2  {left, right} child-present flags.
- rsp_onehot  out  FEATURES  one-hot unit-coefficient position.
- rsp_coeff  out  (FEATURES-1)*COEFF_BIT_DEPTH  other coefficients, two's complement, not sign-extended.
- rsp_bias  out  BIAS_BIT_DEPTH  bias, two's complement.
- rsp_err  out  1  malformed one-hot field (see Configuration).
- mem_ce  out  1  memory chip enable.
- mem_we  out  1  memory write enable.
- mem_a  out  $clog2(WORDS)  memory address.
- mem_d  inout  WORD_W  shared data bus.

## Operation
- Word layout, MSB first: [WORD_W-1] reserved (written 0, ignored on read), then child[1:0], then onehot, then coeff, then bias in the LSBs.
- FSM states: IDLE, WR, RD_ISSUE, RD_CAPTURE, RSP. Only one operation is outstanding at a time.
- IDLE: req_ready=1. On handshake, latch addr and wdata. Go to WR if req_we=1, else RD_ISSUE.
- WR: mem_ce=1, mem_we=1, mem_a=addr, mem_d driven with wdata. Next state IDLE. Writes produce no response.
- RD_ISSUE: mem_ce=1, mem_we=0, mem_a=addr, mem_d released. Next state RD_CAPTURE.
- RD_CAPTURE: mem_ce=0. The memory drives mem_d. Capture mem_d into the response registers at the end of this cycle. Next state RSP.
- RSP: rsp_valid=1, outputs held stable until rsp_ready. On rsp_valid&&rsp_ready, go to IDLE.
- mem_d is driven only when mem_ce&&mem_we; it is high-Z in every other state. This is required because the memory drives the bus whenever it is not being written.
- req_ready=0 in all states except IDLE. Requests presented while busy are not accepted and must be held by the requester.
- mem_ce, mem_we and mem_a are registered outputs.

## Timing
- Read latency: accept at edge E0; bus cycle between E0 and E1; data on mem_d between E1 and E2; rsp_valid=1 after E2.
- Minimum read period is 4 cycles. Minimum write period is 2 cycles.
- Reset values: req_ready=0 while reset is asserted and 1 in IDLE after release; rsp_valid=0, rsp_err=0, mem_ce=0, mem_we=0, mem_a=0, mem_d=Z, all rsp_* fields=0.
- Reset asserted mid-operation: the FSM goes to IDLE immediately and mem_ce/mem_we deassert without waiting for a clock. An in-flight write may or may not have reached the memory. An in-flight read is discarded.
- rsp_ready is ignored outside RSP.

## Configuration
- TREE_NODE_FETCH_ONEHOT_CHECK_EN defined: rsp_err=1 with rsp_valid when the onehot field has zero bits set or more than one bit set. The response is still delivered.
- Macro undefined: rsp_err is tied to 0 and no check logic is built.

## Structure
- Shared package tree_pkg holds:
  - WORD_W and the field offset/width constants, used by the memory, this block and the tree walker;
  - FSM state encoding.
- Sub-module tree_node_unpack: purely combinational split of a WORD_W word into child, onehot, coeff and bias fields, plus the optional one-hot check. It is reused by the tree walker.

## Test plan
- Write 24'h5A1234 to addr 3, then read addr 3 -> mem_d driven only during the WR cycle; rsp_word=24'h5A1234 two cycles after read acceptance; fields split per layout.
- Read addr 0, then read addr WORDS-1 back to back -> two responses in order, with req_ready low for 3 cycles after each acceptance.
- Read with rsp_ready=0 for 5 cycles -> rsp_valid and all fields stable; req_ready=0 throughout; completion on the first cycle rsp_ready=1.
- Read returning onehot=3'b011, then a read returning 3'b000 -> rsp_err=1 for both with the macro defined; rsp_err=0 without it.
- Assert reset during RD_CAPTURE -> mem_ce=0 and rsp_valid=0 immediately; after release, req_ready=1 and a new read of addr 2 completes normally.
- Hold req_valid with req_we=1 during a pending RSP -> no memory write occurs until the response is consumed; mem_d is never driven while the memory is driving it.
